// File: rtl/addsub_operand_loader.sv
// Operand loader for the add/sub stage: collects an A beat and a B beat from
// the upstream stream, then holds the pair on op_a/op_b/op_mode with op_valid
// high until the downstream stage takes it. A flush during LOAD_B throws away
// the half-loaded pair; op_count tracks completed issues modulo 256.
module addsub_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_mode,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        ISSUE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_mode_q, op_mode_d;
    logic             op_valid_q, op_valid_d;
    logic [7:0]       op_count_q, op_count_d;

    logic             in_transfer;
    logic             op_transfer;

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        in_ready    = rst_n && ((state_q == LOAD_A) ||
                                ((state_q == LOAD_B) && !flush));
        in_transfer = in_valid && in_ready;
        op_transfer = op_valid_q && op_ready;
    end

    // Next-state and next-output logic; op_valid follows the next state so it
    // rises on the same edge that accepts the B beat.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_mode_d  = op_mode_q;
        op_count_d = op_count_q;

        case (state_q)
            LOAD_A: begin
                if (in_transfer) begin
                    op_a_d  = in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (flush) begin
                    state_d = LOAD_A;
                end else if (in_transfer) begin
                    op_b_d    = in_data;
                    op_mode_d = in_mode;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (op_transfer) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase

        op_valid_d = (state_d == ISSUE);
    end

    // State and registered outputs; reset abandons any pair in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_mode_q  <= 1'b0;
            op_valid_q <= 1'b0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_mode_q  <= op_mode_d;
            op_valid_q <= op_valid_d;
            op_count_q <= op_count_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_mode  = op_mode_q;
    assign op_valid = op_valid_q;
    assign op_count = op_count_q;

endmodule

// File: doc/addsub_operand_loader.md
ADDSUB_OPERAND_LOADER -- requirements
Module: addsub_operand_loader

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits for in_data, op_a, op_b.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_data  input  WIDTH  operand byte stream: first beat A, second beat B.
REQ-005 Port: in_mode  input  1  operation select, sampled on the B beat only; 0 = add, 1 = subtract.
REQ-006 Port: in_valid  input  1  upstream beat valid.
REQ-007 Port: in_ready  output  1  loader accepts a beat this cycle.
REQ-008 Port: flush  input  1  discard a partially loaded pair.
REQ-009 Port: op_a  output  WIDTH  registered operand A for the add/sub stage.
REQ-010 Port: op_b  output  WIDTH  registered operand B for the add/sub stage.
REQ-011 Port: op_mode  output  1  registered mode for the add/sub stage.
REQ-012 Port: op_valid  output  1  operand pair complete and stable.
REQ-013 Port: op_ready  input  1  downstream stage consumed the pair.
REQ-014 Port: op_count  output  8  number of completed issues, modulo 256.

Function
REQ-015 FSM states SHALL be LOAD_A, LOAD_B and ISSUE, fully encoded; unused encodings SHALL return to LOAD_A on the next edge.
REQ-016 In_transfer SHALL be in_valid && in_ready; op_transfer SHALL be op_valid && op_ready.
REQ-017 in_ready SHALL equal rst_n && ((state==LOAD_A) || (state==LOAD_B && !flush)); it is 0 in ISSUE.
REQ-018 LOAD_A: on in_transfer, op_a <= in_data and state -> LOAD_B; otherwise hold.
REQ-019 LOAD_B: flush high -> state LOAD_A, no beat accepted, op_a unchanged but considered invalid.
REQ-020 LOAD_B: flush low and in_transfer -> op_b <= in_data, op_mode <= in_mode, state -> ISSUE.
REQ-021 op_valid SHALL be registered and high exactly while state==ISSUE; it rises at the edge that accepts the B beat (zero extra cycles of latency).
REQ-022 While op_valid is high, op_a, op_b and op_mode SHALL NOT change.
REQ-023 ISSUE: on op_transfer, state -> LOAD_A and op_count increments; 255 wraps to 0.
REQ-024 ISSUE: op_valid SHALL stay high indefinitely while op_ready is low; flush is ignored in ISSUE and LOAD_A.
REQ-025 Minimum throughput SHALL be one operand pair per 3 cycles with in_valid and op_ready held high.
REQ-026 op_a/op_b/op_mode SHALL be fed unmodified to the add/sub stage; sign, two's-complement and carry handling belong to that stage.
REQ-027 in_data and in_mode SHALL be ignored on beats that are not in_transfer.

Reset
REQ-028 rst_n low SHALL immediately force state LOAD_A, op_a=0, op_b=0, op_mode=0, op_valid=0, op_count=0, in_ready=0.
REQ-029 Reset asserted mid-pair or during ISSUE SHALL abandon the pair without incrementing op_count.
REQ-030 First beat after rst_n rises SHALL be taken as operand A.

Verification
REQ-031 Beats 0x25 then 0x13 with in_mode=1, op_ready=1 -> op_a=0x25, op_b=0x13, op_mode=1, op_valid high one cycle, op_count 0->1.
REQ-032 Pair 0xFF/0x01 mode 0, op_ready low 5 cycles -> op_valid high 5+ cycles, operands stable, in_ready=0, new in_valid beats ignored; op_ready high -> LOAD_A, count+1.
REQ-033 Beat 0x40, then flush=1 with in_valid=1 and 0x77 in LOAD_B -> in_ready=0, no issue; next pair 0x10/0x20 issues as op_a=0x10, op_b=0x20.
REQ-034 256 back-to-back pairs -> op_count returns to 0x00; observed spacing 3 cycles per pair.
REQ-035 rst_n pulled low while op_valid=1 (count=3) -> op_valid=0, op_count=0, op_a=op_b=0 asynchronously, before next clk edge.
REQ-036 in_valid toggling with gaps and in_mode changed on A beat only -> op_mode equals value sampled on B beat.
